// File: rtl/mc_ctrl_fsm.sv
// Multicycle MIPS main controller: Moore FSM that sequences fetch through writeback
// and drives the datapath enables. Optional ORI support is enabled by defining MC_ORI_EN.
module mc_ctrl_fsm #(
    parameter logic [3:0] RESET_STATE = 4'd0
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [5:0] op,
    input  logic       mem_ready,
    output logic       iord,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic       zero_ext,
    output logic [1:0] pc_src,
    output logic [1:0] alu_op,
    output logic       pc_write,
    output logic       branch,
    output logic       illegal_op,
    output logic [3:0] state
);

    // state   | meaning
    // FETCH   | read instruction at PC, PC += 4 (waits on mem_ready)
    // DECODE  | read registers, precompute branch target, dispatch on op
    // MEMADR  | compute load/store address
    // MEMRD   | read data memory (waits on mem_ready)
    // MEMWB   | write loaded data to rt
    // MEMWR   | write data memory (waits on mem_ready)
    // EXECUTE | R-type ALU operation
    // ALUWB   | write ALU result to rd
    // BRANCH  | BEQ compare and conditional PC update
    // ADDIEX  | add sign-extended immediate
    // IWB     | write immediate-op result to rt
    // JUMP    | PC <= jump target
    // ORIEX   | OR zero-extended immediate (MC_ORI_EN only)
    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECUTE = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_ADDIEX  = 4'd9,
        S_IWB     = 4'd10,
        S_JUMP    = 4'd11,
        S_ORIEX   = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    state_t state_q;
    state_t state_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= state_t'(RESET_STATE);
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = S_FETCH;
        iord       = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        zero_ext   = 1'b0;
        pc_src     = 2'b00;
        alu_op     = 2'b00;
        pc_write   = 1'b0;
        branch     = 1'b0;
        illegal_op = 1'b0;

        case (state_q)
            S_FETCH: begin
                alu_src_b = 2'b01;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
                state_d   = mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXECUTE;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JUMP;
`ifdef MC_ORI_EN
                    OP_ORI:       state_d = S_ORIEX;
`endif
                    default: begin
                        illegal_op = 1'b1;
                        state_d    = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                state_d   = (op == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                iord    = 1'b1;
                state_d = mem_ready ? S_MEMWB : S_MEMRD;
            end
            S_MEMWB: begin
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
            end
            S_MEMWR: begin
                iord      = 1'b1;
                mem_write = 1'b1;
                state_d   = mem_ready ? S_FETCH : S_MEMWR;
            end
            S_EXECUTE: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
                state_d   = S_ALUWB;
            end
            S_ALUWB: begin
                reg_dst   = 1'b1;
                reg_write = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b01;
                pc_src    = 2'b01;
                branch    = 1'b1;
            end
            S_ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                state_d   = S_IWB;
            end
            S_IWB: begin
                reg_write = 1'b1;
            end
            S_JUMP: begin
                pc_src   = 2'b10;
                pc_write = 1'b1;
            end
`ifdef MC_ORI_EN
            S_ORIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                zero_ext  = 1'b1;
                alu_op    = 2'b11;
                state_d   = S_IWB;
            end
`endif
            default: state_d = S_FETCH;
        endcase

        // Reset drops every strobe at once, even though the FETCH decode would
        // otherwise let mem_ready through to ir_write/pc_write.
        if (!reset_n) begin
            ir_write   = 1'b0;
            pc_write   = 1'b0;
            mem_write  = 1'b0;
            reg_write  = 1'b0;
            branch     = 1'b0;
            illegal_op = 1'b0;
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Scoreboard bench for mc_ctrl_fsm: driver queues per-cycle expected outputs,
// a negedge monitor pops and compares them against the DUT.
module tb_mc_ctrl_fsm;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [5:0] op;
    logic       mem_ready;
    logic       iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a;
    logic [1:0] alu_src_b, pc_src, alu_op;
    logic       zero_ext, pc_write, branch, illegal_op;
    logic [3:0] state;

    typedef struct packed {
        logic [3:0] st;
        logic       iord;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic       zero_ext;
        logic [1:0] pc_src;
        logic [1:0] alu_op;
        logic       pc_write;
        logic       branch;
        logic       illegal_op;
    } vec_t;

    localparam logic [5:0] LW   = 6'b100011;
    localparam logic [5:0] SW   = 6'b101011;
    localparam logic [5:0] RT   = 6'b000000;
    localparam logic [5:0] BEQ  = 6'b000100;
    localparam logic [5:0] ADDI = 6'b001000;
    localparam logic [5:0] JMP  = 6'b000010;
    localparam logic [5:0] ORI  = 6'b001101;
    localparam logic [5:0] ILL  = 6'b111111;

    vec_t  exp_q[$];
    string name_q[$];
    int    checks = 0;
    int    errors = 0;

    always #5 clk = ~clk;

    mc_ctrl_fsm #(.RESET_STATE(4'd0)) dut (
        .clk(clk), .reset_n(reset_n), .op(op), .mem_ready(mem_ready),
        .iord(iord), .mem_write(mem_write), .ir_write(ir_write), .reg_dst(reg_dst),
        .mem_to_reg(mem_to_reg), .reg_write(reg_write), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .zero_ext(zero_ext), .pc_src(pc_src), .alu_op(alu_op),
        .pc_write(pc_write), .branch(branch), .illegal_op(illegal_op), .state(state)
    );

    // Expected outputs per state, written out from the controller's state table.
    function automatic vec_t exp_vec(int st, bit mr, bit rst, bit ill);
        vec_t e;
        e = '0;
        e.st = 4'(st);
        case (st)
            0:  begin e.alu_src_b = 2'b01; e.ir_write = mr & rst; e.pc_write = mr & rst; end
            1:  begin e.alu_src_b = 2'b11; e.illegal_op = ill; end
            2:  begin e.alu_src_a = 1'b1; e.alu_src_b = 2'b10; end
            3:  e.iord = 1'b1;
            4:  begin e.mem_to_reg = 1'b1; e.reg_write = 1'b1; end
            5:  begin e.iord = 1'b1; e.mem_write = 1'b1; end
            6:  begin e.alu_src_a = 1'b1; e.alu_op = 2'b10; end
            7:  begin e.reg_dst = 1'b1; e.reg_write = 1'b1; end
            8:  begin e.alu_src_a = 1'b1; e.alu_op = 2'b01; e.pc_src = 2'b01; e.branch = 1'b1; end
            9:  begin e.alu_src_a = 1'b1; e.alu_src_b = 2'b10; end
            10: e.reg_write = 1'b1;
            11: begin e.pc_src = 2'b10; e.pc_write = 1'b1; end
            12: begin e.alu_src_a = 1'b1; e.alu_src_b = 2'b10; e.zero_ext = 1'b1; e.alu_op = 2'b11; end
            default: e = '0;
        endcase
        return e;
    endfunction

    // One cycle of stimulus; called just after a rising edge.
    task automatic cyc(input string nm, input bit rst, input logic [5:0] o,
                       input bit mr, input int st, input bit ill = 1'b0);
        reset_n   = rst;
        op        = o;
        mem_ready = mr;
        exp_q.push_back(exp_vec(st, mr, rst, ill));
        name_q.push_back(nm);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            vec_t e, a;
            string nm;
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            a  = '{state, iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
                   alu_src_a, alu_src_b, zero_ext, pc_src, alu_op, pc_write, branch,
                   illegal_op};
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL %s: got %06h (state %0d) expected %06h (state %0d)",
                         nm, a, a.st, e, e.st);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached with %0d entries pending", exp_q.size());
        $fatal(1, "timeout");
    end

    initial begin
        reset_n   = 1'b0;
        op        = RT;
        mem_ready = 1'b1;
        @(posedge clk);
        #1;
        cyc("reset_hold0", 0, RT, 1, 0);
        cyc("reset_hold1", 0, RT, 1, 0);

        // LW: 0,1,2,3,4
        cyc("lw_fetch",  1, LW, 1, 0);
        cyc("lw_decode", 1, LW, 1, 1);
        cyc("lw_memadr", 1, LW, 1, 2);
        cyc("lw_memrd",  1, LW, 1, 3);
        cyc("lw_memwb",  1, LW, 1, 4);

        // R-type: 0,1,6,7
        cyc("rt_fetch",  1, RT, 1, 0);
        cyc("rt_decode", 1, RT, 1, 1);
        cyc("rt_exec",   1, RT, 1, 6);
        cyc("rt_aluwb",  1, RT, 1, 7);

        // BEQ: 0,1,8
        cyc("beq_fetch",  1, BEQ, 1, 0);
        cyc("beq_decode", 1, BEQ, 1, 1);
        cyc("beq_branch", 1, BEQ, 1, 8);

        // SW with three wait cycles in MEMWR
        cyc("sw_fetch",  1, SW, 1, 0);
        cyc("sw_decode", 1, SW, 1, 1);
        cyc("sw_memadr", 1, SW, 1, 2);
        for (int i = 0; i < 3; i++) cyc("sw_memwr_wait", 1, SW, 0, 5);
        cyc("sw_memwr_done", 1, SW, 1, 5);

        // ADDI with two wait cycles in FETCH
        cyc("addi_fetch_wait0", 1, ADDI, 0, 0);
        cyc("addi_fetch_wait1", 1, ADDI, 0, 0);
        cyc("addi_fetch",  1, ADDI, 1, 0);
        cyc("addi_decode", 1, ADDI, 1, 1);
        cyc("addi_ex",     1, ADDI, 1, 9);
        cyc("addi_iwb",    1, ADDI, 1, 10);

        // ORI
        cyc("ori_fetch", 1, ORI, 1, 0);
`ifdef MC_ORI_EN
        cyc("ori_decode", 1, ORI, 1, 1);
        cyc("ori_ex",     1, ORI, 1, 12);
        cyc("ori_iwb",    1, ORI, 1, 10);
`else
        cyc("ori_decode_illegal", 1, ORI, 1, 1, 1'b1);
`endif

        // Illegal opcode for one cycle, then J: 0,1,11
        cyc("ill_fetch",  1, ILL, 1, 0);
        cyc("ill_decode", 1, ILL, 1, 1, 1'b1);
        cyc("j_fetch",    1, JMP, 1, 0);
        cyc("j_decode",   1, JMP, 1, 1);
        cyc("j_jump",     1, JMP, 1, 11);

        // Reset in the middle of a stalled store
        cyc("sw2_fetch",  1, SW, 1, 0);
        cyc("sw2_decode", 1, SW, 1, 1);
        cyc("sw2_memadr", 1, SW, 1, 2);
        cyc("sw2_memwr",  1, SW, 0, 5);
        cyc("reset_mid_memwr", 0, SW, 0, 0);
        cyc("reset_mid_hold",  0, SW, 1, 0);
        cyc("post_reset_fetch",  1, LW, 1, 0);
        cyc("post_reset_decode", 1, LW, 1, 1);

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mc_ctrl_fsm.md
# mc_ctrl_fsm

Multicycle main controller for the MIPS core: a Moore state machine that sequences fetch, decode, execute, memory and writeback, and drives every datapath enable. It is the producer side of the 2-bit `alu_op` interface that `aludec` consumes:
- 00 = add
- 01 = subtract
- 10 = R-type, decode `funct`
- 11 = or

It sits between the instruction register's opcode field and the shared-memory multicycle datapath, and adds a `mem_ready` wait handshake on every memory access.

## Interface
Parameters:
- `RESET_STATE`, 4'd0 — state code entered on reset; must be FETCH.

Ports:
- `clk` in 1 — rising-edge clock.
- `reset_n` in 1 — asynchronous, active-low reset.
- `op` in 6 — opcode field, `instr[31:26]`, from the instruction register.
- `mem_ready` in 1 — memory has completed the current access this cycle.
- `iord` out 1 — memory address select: 0 = PC, 1 = ALUOut.
- `mem_write` out 1 — memory write strobe.
- `ir_write` out 1 — instruction register load.
- `reg_dst` out 1 — destination register: 1 = rd, 0 = rt.
- `mem_to_reg` out 1 — writeback source: 1 = Data register, 0 = ALUOut.
- `reg_write` out 1 — register file write.
- `alu_src_a` out 1 — ALU A input: 0 = PC, 1 = register A.
- `alu_src_b` out 2 — ALU B input: 00 = register B, 01 = 4, 10 = extended immediate, 11 = immediate<<2.
- `zero_ext` out 1 — immediate is zero-extended rather than sign-extended.
- `pc_src` out 2 — next PC: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- `alu_op` out 2 — to `aludec`.
- `pc_write` out 1 — unconditional PC write.
- `branch` out 1 — conditional PC write; the datapath forms `pc_en = pc_write | (branch & zero)`.
- `illegal_op` out 1 — unsupported opcode seen in DECODE.
- `state` out 4 — current state, for debug and verification.

## Operation
- Outputs are decoded combinationally from `state` only (Moore), with one exception: `ir_write` and `pc_write` in FETCH are ANDed with `mem_ready`.
- Any output not listed for a state is 0.
- States are listed as code name: outputs -> next state.
  - 0 FETCH: `alu_src_b`=01, `alu_op`=00, `ir_write`=`pc_write`=`mem_ready` -> DECODE if `mem_ready`, else stay.
  - 1 DECODE: `alu_src_b`=11, `alu_op`=00 -> next state by `op`:
    - LW 100011 or SW 101011 -> MEMADR
    - R-type 000000 -> EXECUTE
    - BEQ 000100 -> BRANCH
    - ADDI 001000 -> ADDIEX
    - J 000010 -> JUMP
    - ORI 001101 -> ORIEX
    - anything else -> FETCH, with `illegal_op`=1 during this DECODE cycle
  - 2 MEMADR: `alu_src_a`=1, `alu_src_b`=10, `alu_op`=00 -> MEMRD for LW, MEMWR for SW.
  - 3 MEMRD: `iord`=1 -> MEMWB if `mem_ready`, else stay.
  - 4 MEMWB: `mem_to_reg`=1, `reg_write`=1 -> FETCH.
  - 5 MEMWR: `iord`=1, `mem_write`=1 (held high while waiting) -> FETCH if `mem_ready`, else stay.
  - 6 EXECUTE: `alu_src_a`=1, `alu_src_b`=00, `alu_op`=10 -> ALUWB.
  - 7 ALUWB: `reg_dst`=1, `reg_write`=1 -> FETCH.
  - 8 BRANCH: `alu_src_a`=1, `alu_op`=01, `pc_src`=01, `branch`=1 -> FETCH.
  - 9 ADDIEX: `alu_src_a`=1, `alu_src_b`=10, `alu_op`=00 -> IWB.
  - 10 IWB: `reg_write`=1, `reg_dst`=0, `mem_to_reg`=0 -> FETCH.
  - 11 JUMP: `pc_src`=10, `pc_write`=1 -> FETCH.
  - 12 ORIEX: `alu_src_a`=1, `alu_src_b`=10, `zero_ext`=1, `alu_op`=11 -> IWB.
- Codes 13–15 are unreachable. If one is entered, all outputs are 0 and the next state is FETCH.
- `op` is sampled only in DECODE and MEMADR. The datapath holds `instr` stable because `ir_write` is 0 outside FETCH.

## Timing
- The state register updates on `posedge clk`. `reset_n` low forces `state`=FETCH immediately, without waiting for a clock edge.
- While `reset_n`=0: `ir_write`, `pc_write`, `mem_write`, `reg_write`, `branch` and `illegal_op` are forced to 0. All other outputs take FETCH values: `alu_src_b`=01, everything else 0.
- Reset mid-instruction, including during MEMWR with `mem_write` high, drops every strobe in the same cycle. No partial writeback occurs.
- Release of reset is synchronized externally. The first `posedge` after release starts a normal FETCH.
- Cycle counts with `mem_ready` tied high:
  - LW: 5
  - SW, R-type, ADDI, ORI: 4
  - BEQ, J: 3
- Each cycle with `mem_ready`=0 in FETCH, MEMRD or MEMWR adds one cycle. The wait is unbounded.
- `mem_ready` has no effect in other states.

## Configuration
- `MC_ORI_EN` defined: the ORI decode and ORIEX state exist, and `alu_op`=11 can be produced.
- `MC_ORI_EN` undefined: opcode 001101 is treated as illegal (DECODE -> FETCH with `illegal_op`=1), code 12 behaves as an unreachable state, `zero_ext` is constant 0, and `alu_op` never equals 11.

## Test plan
- Reset: assert `reset_n`=0 mid-MEMWR with `mem_write`=1 -> `mem_write`=0 combinationally, `state`=0. Release reset, hold `mem_ready`=1 -> `ir_write`=`pc_write`=1 in the first cycle.
- LW with `mem_ready`=1, `op`=100011 -> states 0,1,2,3,4,0. `reg_write`=1 and `mem_to_reg`=1 only in state 4. `alu_op`=00 throughout.
- R-type then BEQ -> EXECUTE shows `alu_op`=10 and ALUWB shows `reg_dst`=1; the BEQ sequence is 0,1,8 with `alu_op`=01, `branch`=1, `pc_src`=01 in state 8.
- Wait states: SW with `mem_ready` low for 3 cycles in MEMWR -> `state` stays 5 with `mem_write`=1 for 4 cycles, then FETCH. FETCH with `mem_ready` low for 2 cycles -> `ir_write`=0 until `mem_ready` rises.
- ORI `op`=001101 -> with `MC_ORI_EN` defined: states 0,1,12,10 with `alu_op`=11 and `zero_ext`=1. Without it: `illegal_op`=1 in DECODE, then `state`=0.
- Illegal `op`=111111 and J `op`=000010 -> illegal gives `illegal_op` for exactly 1 cycle and returns to FETCH. J gives sequence 0,1,11 with `pc_src`=10 and `pc_write`=1.
